// File: rtl/prf_free_list_pkg.sv
// Shared rename-stage types: physical register width, allocation request and
// release/commit bundles, and the ring-pointer increment used by the free list.
`ifndef PRF_NUM_WIDTH
`define PRF_NUM_WIDTH 6
`endif

package prf_free_list_pkg;

   localparam int PRF_NUM_W = `PRF_NUM_WIDTH;
   localparam int PRF_DEPTH = 2**PRF_NUM_W;

   typedef logic [PRF_NUM_W-1:0] prf_t;
   // One extra MSB on queue pointers acts as the wrap bit.
   typedef logic [PRF_NUM_W:0]   prf_ptr_t;

   typedef struct packed {
      logic req_1;
      logic req_0;
   } prf_alloc_req;

   typedef struct packed {
      logic valid;
      logic wr;
      prf_t stale_prf;
   } prf_release_info;

   // One commit bus feeds both the committed map table and the free list.
   typedef struct packed {
      logic       valid;
      logic       wr;
      logic [4:0] arch_rd;
      prf_t       prf_rd;
      prf_t       committed_stale_prf;
   } commit_info;

   function automatic prf_ptr_t ptr_ring_inc(input prf_ptr_t ptr, input logic [1:0] n);
      return ptr + prf_ptr_t'(n);
   endfunction

endpackage

// File: rtl/prf_free_list.sv
// Circular free list of physical registers for 2-wide rename: speculative head
// for allocation, committed head for recovery, tail for reclaimed stale prfs.
module prf_free_list
   import prf_free_list_pkg::*;
#(
   parameter int PRF_W = PRF_NUM_W,
   parameter int DEPTH = PRF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             recover,
   input  logic             alloc_req_0,
   input  logic             alloc_req_1,
   output logic [PRF_W-1:0] alloc_prf_0,
   output logic [PRF_W-1:0] alloc_prf_1,
   output logic             alloc_stall,
   input  logic             commit_valid_0,
   input  logic             commit_valid_1,
   input  logic             commit_wr_0,
   input  logic             commit_wr_1,
   input  logic [PRF_W-1:0] commit_stale_prf_0,
   input  logic [PRF_W-1:0] commit_stale_prf_1,
   output logic [PRF_W:0]   free_count
);

   logic [PRF_W-1:0] q [DEPTH];

   prf_ptr_t spec_head, cmt_head, tail;
   prf_ptr_t spec_head_next, cmt_head_next, tail_next;

   prf_alloc_req    req;
   prf_release_info rel_info_0, rel_info_1;

   logic [1:0]       nreq, ncmt, nrel;
   logic             rel_0, rel_1, cmt_0, cmt_1, grant;
   logic [PRF_W-1:0] spec_idx, tail_idx, tail_idx_1;

   always_comb begin
      req.req_0            = alloc_req_0;
      req.req_1            = alloc_req_1;
      rel_info_0.valid     = commit_valid_0;
      rel_info_0.wr        = commit_wr_0;
      rel_info_0.stale_prf = commit_stale_prf_0;
      rel_info_1.valid     = commit_valid_1;
      rel_info_1.wr        = commit_wr_1;
      rel_info_1.stale_prf = commit_stale_prf_1;
   end

   always_comb begin
      spec_idx   = spec_head[PRF_W-1:0];
      tail_idx   = tail[PRF_W-1:0];
      nreq       = {1'b0, req.req_0} + {1'b0, req.req_1};
      free_count = tail - spec_head;

      alloc_stall = recover || ({{(PRF_W-1){1'b0}}, nreq} > free_count);
      grant       = !alloc_stall;

      alloc_prf_0 = q[spec_idx];
      alloc_prf_1 = req.req_0 ? q[spec_idx + {{(PRF_W-1){1'b0}}, 1'b1}] : q[spec_idx];

      // A commit of an instruction whose old mapping was P0 still retires
      // (moves cmt_head) but has nothing to give back.
      cmt_0 = rel_info_0.valid && rel_info_0.wr;
      cmt_1 = rel_info_1.valid && rel_info_1.wr;
      rel_0 = cmt_0 && (rel_info_0.stale_prf != '0);
      rel_1 = cmt_1 && (rel_info_1.stale_prf != '0);
      ncmt  = {1'b0, cmt_0} + {1'b0, cmt_1};
      nrel  = {1'b0, rel_0} + {1'b0, rel_1};

      tail_idx_1 = rel_0 ? tail_idx + {{(PRF_W-1){1'b0}}, 1'b1} : tail_idx;

      tail_next     = ptr_ring_inc(tail, nrel);
      cmt_head_next = ptr_ring_inc(cmt_head, ncmt);
      if (recover)
         spec_head_next = cmt_head_next;
      else if (grant)
         spec_head_next = ptr_ring_inc(spec_head, nreq);
      else
         spec_head_next = spec_head;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spec_head <= '0;
         cmt_head  <= '0;
         tail      <= prf_ptr_t'(DEPTH - 1);
         // Slot i holds P(i+1); the last slot truncates to P0 and is unused.
         for (int i = 0; i < DEPTH; i++)
            q[i] <= PRF_W'(i + 1);
      end else begin
         spec_head <= spec_head_next;
         cmt_head  <= cmt_head_next;
         tail      <= tail_next;
         if (rel_0)
            q[tail_idx] <= rel_info_0.stale_prf;
         if (rel_1)
            q[tail_idx_1] <= rel_info_1.stale_prf;
      end
   end

`ifdef DEBUG
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (free_count <= (PRF_W+1)'(DEPTH - 1))
            else $error("free list overfilled");
         assert (prf_ptr_t'(spec_head - cmt_head) <= prf_ptr_t'(DEPTH - 1))
            else $error("committed head passed speculative head");
      end
   end
`endif

endmodule

// File: tb/tb_prf_free_list.sv
// Self-checking bench for prf_free_list: directed vector table, hand-written
// corner sequences, then random rename/commit/recover against a queue model.
module tb_prf_free_list;
   import prf_free_list_pkg::*;

   logic       clk;
   logic       rst;
   logic       recover;
   logic       alloc_req_0, alloc_req_1;
   logic [5:0] alloc_prf_0, alloc_prf_1;
   logic       alloc_stall;
   logic       commit_valid_0, commit_valid_1;
   logic       commit_wr_0, commit_wr_1;
   logic [5:0] commit_stale_prf_0, commit_stale_prf_1;
   logic [6:0] free_count;

   prf_free_list dut (
      .clk                (clk),
      .rst                (rst),
      .recover            (recover),
      .alloc_req_0        (alloc_req_0),
      .alloc_req_1        (alloc_req_1),
      .alloc_prf_0        (alloc_prf_0),
      .alloc_prf_1        (alloc_prf_1),
      .alloc_stall        (alloc_stall),
      .commit_valid_0     (commit_valid_0),
      .commit_valid_1     (commit_valid_1),
      .commit_wr_0        (commit_wr_0),
      .commit_wr_1        (commit_wr_1),
      .commit_stale_prf_0 (commit_stale_prf_0),
      .commit_stale_prf_1 (commit_stale_prf_1),
      .free_count         (free_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // rs rc r0 r1: reset, recover, requests; c0/c1: commit valid+wr with stale s0/s1;
   // ck: check enable; st/p0/p1/fc: expected stall, prfs (-1 = don't care), free_count.
   typedef struct {
      int rs, rc, r0, r1, c0, s0, c1, s1;
      int ck, st, p0, p1, fc;
   } vec_t;

   function automatic vec_t v(input int rs, rc, r0, r1, c0, s0, c1, s1,
                              input int ck, st, p0, p1, fc);
      vec_t x;
      x.rs = rs; x.rc = rc; x.r0 = r0; x.r1 = r1;
      x.c0 = c0; x.s0 = s0; x.c1 = c1; x.s1 = s1;
      x.ck = ck; x.st = st; x.p0 = p0; x.p1 = p1; x.fc = fc;
      return x;
   endfunction

   task automatic apply_vec(input vec_t x, input string tag);
      @(negedge clk);
      rst                = (x.rs != 0);
      recover            = (x.rc != 0);
      alloc_req_0        = (x.r0 != 0);
      alloc_req_1        = (x.r1 != 0);
      commit_valid_0     = (x.c0 != 0);
      commit_wr_0        = (x.c0 != 0);
      commit_stale_prf_0 = 6'(x.s0);
      commit_valid_1     = (x.c1 != 0);
      commit_wr_1        = (x.c1 != 0);
      commit_stale_prf_1 = 6'(x.s1);
      #1;
      if (x.ck != 0) begin
         chk({tag, ".stall"}, int'(alloc_stall), x.st);
         chk({tag, ".free"}, int'(free_count), x.fc);
         if (x.p0 >= 0) chk({tag, ".p0"}, int'(alloc_prf_0), x.p0);
         if (x.p1 >= 0) chk({tag, ".p1"}, int'(alloc_prf_1), x.p1);
      end
   endtask

   function automatic vec_t v_rst();
      return v(1,0,0,0,0,0,0,0, 0,0,-1,-1,0);
   endfunction

   // Reference model: the committed free list in order, plus how many of its
   // leading entries are speculatively handed out.
   typedef struct { int arch; int newp; int stale; } rob_t;
   localparam int NA = 8;
   int   cmt_free[$];
   int   spec_cnt;
   rob_t rob[$];
   int   spec_map[NA];
   int   cmt_map[NA];
   bit   in_use[64];

   task automatic model_reset();
      cmt_free.delete();
      for (int p = 1; p < 64; p++) cmt_free.push_back(p);
      spec_cnt = 0;
      rob.delete();
      for (int a = 0; a < NA; a++) begin spec_map[a] = 0; cmt_map[a] = 0; end
      for (int p = 0; p < 64; p++) in_use[p] = 1'b0;
   endtask

   task automatic rand_cycle(input bit rec, input bit r0, input bit r1, input bit allow_commit);
      bit vld[2], wr[2];
      int st_prf[2];
      int idx, nreq, nfree, e0, e1, g0, g1;
      bit stall;
      idx = 0;
      for (int k = 0; k < 2; k++) begin
         vld[k]    = allow_commit && ($urandom_range(0, 2) != 0);
         wr[k]     = 1'b0;
         st_prf[k] = $urandom_range(0, 63);
         if (vld[k] && idx < rob.size() && $urandom_range(0, 5) != 0) begin
            wr[k]     = 1'b1;
            st_prf[k] = rob[idx].stale;
            idx++;
         end else if (!vld[k]) begin
            wr[k] = 1'($urandom_range(0, 1));
         end
      end
      nreq  = int'(r0) + int'(r1);
      nfree = cmt_free.size() - spec_cnt;
      stall = rec || (nreq > nfree);
      e0 = -1; e1 = -1;
      if (!stall && r0) e0 = cmt_free[spec_cnt];
      if (!stall && r1) e1 = r0 ? cmt_free[spec_cnt + 1] : cmt_free[spec_cnt];

      @(negedge clk);
      rst                = 1'b0;
      recover            = rec;
      alloc_req_0        = r0;
      alloc_req_1        = r1;
      commit_valid_0     = vld[0];
      commit_wr_0        = wr[0];
      commit_stale_prf_0 = 6'(st_prf[0]);
      commit_valid_1     = vld[1];
      commit_wr_1        = wr[1];
      commit_stale_prf_1 = 6'(st_prf[1]);
      #1;
      chk("rnd.free", int'(free_count), nfree);
      chk("rnd.stall", int'(alloc_stall), int'(stall));
      g0 = int'(alloc_prf_0);
      g1 = int'(alloc_prf_1);
      if (!stall && r0) begin
         chk("rnd.p0", g0, e0);
         chk("rnd.p0_dup", int'(in_use[g0]), 0);
      end
      if (!stall && r1) begin
         chk("rnd.p1", g1, e1);
         chk("rnd.p1_dup", int'(in_use[g1]), 0);
      end

      @(posedge clk);
      for (int k = 0; k < idx; k++) begin
         rob_t ent;
         ent = rob.pop_front();
         cmt_map[ent.arch] = ent.newp;
         void'(cmt_free.pop_front());
         spec_cnt--;
      end
      if (!stall) begin
         if (r0) begin
            rob_t ent;
            ent.arch = $urandom_range(0, NA - 1);
            ent.newp = e0; ent.stale = spec_map[ent.arch];
            spec_map[ent.arch] = e0;
            rob.push_back(ent);
            in_use[g0] = 1'b1;
            spec_cnt++;
         end
         if (r1) begin
            rob_t ent;
            ent.arch = $urandom_range(0, NA - 1);
            ent.newp = e1; ent.stale = spec_map[ent.arch];
            spec_map[ent.arch] = e1;
            rob.push_back(ent);
            in_use[g1] = 1'b1;
            spec_cnt++;
         end
      end
      for (int k = 0; k < 2; k++)
         if (vld[k] && wr[k] && st_prf[k] != 0) begin
            cmt_free.push_back(st_prf[k]);
            in_use[st_prf[k]] = 1'b0;
         end
      if (rec) begin
         foreach (rob[i]) in_use[rob[i].newp] = 1'b0;
         rob.delete();
         spec_cnt = 0;
         for (int a = 0; a < NA; a++) spec_map[a] = cmt_map[a];
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t tbl[14];

   initial begin
      int missing;
      rst = 1'b1; recover = 1'b0; alloc_req_0 = 1'b0; alloc_req_1 = 1'b0;
      commit_valid_0 = 1'b0; commit_valid_1 = 1'b0; commit_wr_0 = 1'b0; commit_wr_1 = 1'b0;
      commit_stale_prf_0 = '0; commit_stale_prf_1 = '0;

      //            rs rc r0 r1 c0 s0 c1 s1  ck st p0  p1  fc
      tbl[0]  = v_rst();
      tbl[1]  = v(0, 0, 1, 1, 0, 0, 0, 0,  1, 0, 1,  2,  63);
      tbl[2]  = v(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, -1, -1, 61);
      tbl[3]  = v_rst();
      tbl[4]  = v(0, 0, 0, 1, 0, 0, 0, 0,  1, 0, -1, 1,  63);
      tbl[5]  = v(0, 0, 1, 1, 0, 0, 0, 0,  1, 0, 2,  3,  62);
      tbl[6]  = v(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, -1, -1, 60);
      tbl[7]  = v_rst();
      tbl[8]  = v(0, 0, 1, 1, 0, 0, 0, 0,  1, 0, 1,  2,  63);
      tbl[9]  = v(0, 0, 1, 1, 0, 0, 0, 0,  1, 0, 3,  4,  61);
      tbl[10] = v(0, 0, 0, 0, 1, 0, 1, 0,  1, 0, -1, -1, 59);
      tbl[11] = v(0, 1, 1, 0, 0, 0, 0, 0,  1, 1, -1, -1, 59);
      tbl[12] = v(0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 3,  -1, 61);
      tbl[13] = v(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, -1, -1, 60);
      for (int i = 0; i < 14; i++)
         apply_vec(tbl[i], $sformatf("vec%0d", i));

      // Drain to one free entry, then the two-wide and empty-list stalls.
      apply_vec(v_rst(), "drain.rst");
      for (int i = 0; i < 31; i++)
         apply_vec(v(0,0,1,1,0,0,0,0, 1,0, 2*i+1, 2*i+2, 63-2*i), $sformatf("drain%0d", i));
      apply_vec(v(0,0,1,1,0,0,0,0, 1,1,-1,-1, 1), "drain.stall2");
      apply_vec(v(0,0,1,0,0,0,0,0, 1,0,63,-1, 1), "drain.last");
      apply_vec(v(0,0,0,1,0,0,0,0, 1,1,-1,-1, 0), "drain.empty");

      // Release in the same cycle as a two-wide grant, then reuse across the wrap.
      apply_vec(v_rst(), "rel.rst");
      for (int i = 0; i < 30; i++)
         apply_vec(v(0,0,1,1,0,0,0,0, 0,0,-1,-1,0), "rel.fill");
      apply_vec(v(0,0,1,0,0,0,0,0, 1,0,61,-1, 3), "rel.single");
      apply_vec(v(0,0,1,1,1,5,1,9, 1,0,62,63, 2), "rel.same_cycle");
      apply_vec(v(0,0,1,1,0,0,0,0, 1,0, 5, 9, 2), "rel.wrap");
      apply_vec(v(0,0,0,0,0,0,0,0, 1,0,-1,-1, 0), "rel.empty");

      // Random rename/commit traffic against the model.
      apply_vec(v_rst(), "rnd.rst");
      model_reset();
      for (int c = 0; c < 200; c++)
         rand_cycle($urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 9) < 6, 1'b1);
      rand_cycle(1'b1, 1'b0, 1'b0, 1'b1);
      begin
         int n;
         n = cmt_free.size() - spec_cnt;
         for (int i = 0; i < n; i++)
            rand_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      end
      @(negedge clk);
      alloc_req_0 = 1'b0; alloc_req_1 = 1'b0; recover = 1'b0;
      commit_valid_0 = 1'b0; commit_valid_1 = 1'b0;
      #1;
      chk("final.free", int'(free_count), 0);
      missing = 0;
      for (int p = 1; p < 64; p++) if (!in_use[p]) missing++;
      chk("final.union_missing", missing, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
